// File: rtl/ram_access_ctrl.sv
// Request-side controller for a row-select binary RAM array: one-cycle write/read
// strobes to a single one-hot row, registered response with valid/ready backpressure.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [(2**ADDR_W)-1:0]   ram_sel,
  output logic                     ram_rdwr,
  output logic [DATA_W-1:0]        ram_in,
  input  logic [DATA_W-1:0]        ram_out
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic                   req_ready_nxt;
  logic                   rsp_valid_nxt;
  logic [DATA_W-1:0]      rsp_rdata_nxt;
  logic [NUM_WORDS-1:0]   ram_sel_nxt;
  logic                   ram_rdwr_nxt;
  logic [DATA_W-1:0]      ram_in_nxt;

  // State and every output are flops; the array pins only change on clock edges
  // or asynchronously to their safe (no-write) reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_sel   <= '0;
      ram_rdwr  <= 1'b1;
      ram_in    <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      ram_sel   <= ram_sel_nxt;
      ram_rdwr  <= ram_rdwr_nxt;
      ram_in    <= ram_in_nxt;
    end
  end

  // Next state and next output values; the request fields are captured directly
  // into the array-facing output registers on acceptance.
  always_comb begin
    state_nxt     = state;
    req_ready_nxt = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    ram_sel_nxt   = '0;
    ram_rdwr_nxt  = 1'b1;
    ram_in_nxt    = '0;

    unique case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid) begin
          req_ready_nxt = 1'b0;
          ram_sel_nxt   = NUM_WORDS'(1) << req_addr;
          if (req_wr) begin
            state_nxt    = WRITE;
            ram_rdwr_nxt = 1'b0;
            ram_in_nxt   = req_wdata;
          end else begin
            state_nxt    = READ;
          end
        end
      end
      WRITE: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = '0;
      end
      READ: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = ram_out;
      end
      RESP: begin
        rsp_valid_nxt = 1'b1;
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a behavioural 4x4 row-select array model.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic [3:0] ram_sel;
  logic       ram_rdwr;
  logic [3:0] ram_in;
  logic [3:0] ram_out;

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  int exp_rsp_cnt = 0;

  ram_access_ctrl #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_sel(ram_sel), .ram_rdwr(ram_rdwr), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Array model: selected rows latch ram_in on a clock edge when ram_rdwr=0.
  logic [3:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = 4'h0;

  always @(posedge clk) begin
    if (!ram_rdwr)
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) mem[i] <= ram_in;
  end

  always_comb begin
    ram_out = 4'h0;
    for (int i = 0; i < 4; i++)
      if (ram_sel[i]) ram_out = ram_out | mem[i];
  end

  always @(posedge clk)
    if (rst_n && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response transaction with optional response backpressure.
  task automatic do_req(input logic wr, input logic [1:0] addr, input logic [3:0] wdata,
                        input logic [3:0] exp_sel, input logic [3:0] exp_rdata,
                        input int hold);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    check("access_sel",   {28'b0, ram_sel}, {28'b0, exp_sel});
    check("access_rdwr",  {31'b0, ram_rdwr}, {31'b0, ~wr});
    check("access_in",    {28'b0, ram_in}, wr ? {28'b0, wdata} : 32'd0);
    check("access_ready", {31'b0, req_ready}, 32'd0);
    tick();
    exp_rsp_cnt++;
    check("rsp_valid",  {31'b0, rsp_valid}, 32'd1);
    check("rsp_rdata",  {28'b0, rsp_rdata}, {28'b0, exp_rdata});
    check("resp_sel",   {28'b0, ram_sel}, 32'd0);
    check("resp_rdwr",  {31'b0, ram_rdwr}, 32'd1);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", {28'b0, rsp_rdata}, {28'b0, exp_rdata});
      check("hold_ready", {31'b0, req_ready}, 32'd0);
      check("hold_sel",   {28'b0, ram_sel}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_ready", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_sel;
    logic [3:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 4'b1011, 4'b0100, 4'h0};
    vecs[1]  = '{1'b0, 2'd2, 4'h0,    4'b0100, 4'b1011};
    vecs[2]  = '{1'b1, 2'd0, 4'd5,    4'b0001, 4'h0};
    vecs[3]  = '{1'b1, 2'd1, 4'd6,    4'b0010, 4'h0};
    vecs[4]  = '{1'b1, 2'd2, 4'd7,    4'b0100, 4'h0};
    vecs[5]  = '{1'b1, 2'd3, 4'd8,    4'b1000, 4'h0};
    vecs[6]  = '{1'b0, 2'd0, 4'h0,    4'b0001, 4'd5};
    vecs[7]  = '{1'b0, 2'd1, 4'h0,    4'b0010, 4'd6};
    vecs[8]  = '{1'b0, 2'd2, 4'h0,    4'b0100, 4'd7};
    vecs[9]  = '{1'b0, 2'd3, 4'h0,    4'b1000, 4'd8};
    vecs[10] = '{1'b1, 2'd1, 4'hF,    4'b0010, 4'h0};
    vecs[11] = '{1'b0, 2'd1, 4'h0,    4'b0010, 4'hF};
    vecs[12] = '{1'b1, 2'd1, 4'h0,    4'b0010, 4'h0};
    vecs[13] = '{1'b0, 2'd1, 4'h0,    4'b0010, 4'h0};
    vecs[14] = '{1'b0, 2'd0, 4'h0,    4'b0001, 4'd5};
    vecs[15] = '{1'b0, 2'd2, 4'h0,    4'b0100, 4'd7};
    vecs[16] = '{1'b0, 2'd3, 4'h0,    4'b1000, 4'd8};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 2'd0;
    req_wdata = 4'h0; rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {28'b0, rsp_rdata}, 32'd0);
    check("rst_ram_sel",   {28'b0, ram_sel}, 32'd0);
    check("rst_ram_rdwr",  {31'b0, ram_rdwr}, 32'd1);
    check("rst_ram_in",    {28'b0, ram_in}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++)
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_sel, vecs[i].exp_rdata, 0);

    // Backpressure: response held five cycles.
    do_req(1'b0, 2'd3, 4'h0, 4'b1000, 4'd8, 5);

    // Reset during the WRITE cycle: array pins must drop to safe values at once.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd0; req_wdata = 4'hA;
    tick();
    req_valid = 1'b0;
    check("mid_write_sel",  {28'b0, ram_sel}, 32'd1);
    check("mid_write_rdwr", {31'b0, ram_rdwr}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_sel",   {28'b0, ram_sel}, 32'd0);
    check("rst_async_rdwr",  {31'b0, ram_rdwr}, 32'd1);
    check("rst_async_ready", {31'b0, req_ready}, 32'd1);
    tick();
    check("rst_hold_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    do_req(1'b0, 2'd0, 4'h0, 4'b0001, 4'd5, 0);

    // Busy ignore: req_valid stays high with a new address while READ/RESP.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd0;
    tick();
    req_addr = 2'd1;
    check("busy_read_sel", {28'b0, ram_sel}, 32'd1);
    tick();
    exp_rsp_cnt++;
    check("busy_rsp_rdata", {28'b0, rsp_rdata}, 32'd5);
    tick();
    check("busy_hold_valid", {31'b0, rsp_valid}, 32'd1);
    check("busy_hold_sel",   {28'b0, ram_sel}, 32'd0);
    check("busy_hold_ready", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("busy_idle_ready", {31'b0, req_ready}, 32'd1);
    check("busy_idle_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    check("busy2_sel",  {28'b0, ram_sel}, 32'd2);
    check("busy2_rdwr", {31'b0, ram_rdwr}, 32'd1);
    tick();
    exp_rsp_cnt++;
    check("busy2_rdata", {28'b0, rsp_rdata}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    check("rsp_count", rsp_cnt, exp_rsp_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
